controle_acesso_parametrizado: RTL and testbench
================================================

# controle_acesso_parametrizado

Parametrised parking-gate controller that replaces the fixed password/main/light state machines with one configurable block. It handles entry (vehicle at the external sensor, password on the four buttons, gate opens, car passes) and exit (vehicle at the internal sensor, gate opens without a password). It keeps an occupancy counter against a configurable capacity, and locks the keypad out after repeated wrong codes. It sits between the debounced button pulses / raw sensors and the phrase encoder, 7-segment multiplexer and LEDs.

## Interface
Parameters:
- CLK_HZ, 50_000_000: board clock frequency; sets the internal 1 s tick.
- CAPACIDADE, 16: number of parking spaces; must be ≥1.
- SENHA_DIGITOS, 4: password length in digits, 1..8.
- SENHA, 8'b00_01_10_11: password, 2 bits per digit, first digit in the MSBs; width 2*SENHA_DIGITOS.
- TIMEOUT_S, 20: seconds allowed in SENHA, ENTRADA or SAIDA before abort.
- ERRO_S, 2: seconds the error phrase is shown.
- MAX_TENTATIVAS, 3: wrong codes before lockout.
- BLOQUEIO_S, 30: lockout duration in seconds.

Ports:
- CLK_DA_PLACA  in  1  board clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- SENSOR_EXTERNO  in  1  raw external presence sensor, active high.
- SENSOR_INTERNO  in  1  raw internal presence sensor, active high.
- BOTOES  in  4  debounced one-cycle pulses; bit i means digit value i.
- CANCELA_DO_ESTACIONAMENTO  out  1  1 = gate open.
- LED_VERDE  out  1  access granted.
- LED_VERMELHO  out  1  error or lockout.
- LED_AZUL  out  1  blinks at 0.5 Hz while a password is awaited.
- ESTADO_FRASE  out  4  one-hot phrase select: [3] ERRO, [2] LIBERADO, [1] PARE, [0] CHEIO; 0 = display off.
- OCUPACAO  out  $clog2(CAPACIDADE+1)  vehicles inside.
- CHEIO  out  1  OCUPACAO == CAPACIDADE.

## Operation
- Sensors pass through 2-flop synchronisers. All decisions use the synchronised levels and rising edges.
- Prescaler and second counter restart on every state change.
- A tick is issued each CLK_HZ cycles after entering a state. The timeout fires on tick number N.

State machine:
- OCIOSO: all outputs 0 except ESTADO_FRASE[0] = CHEIO & SENSOR_EXTERNO.
  - External rising edge with !CHEIO → SENHA.
  - Internal rising edge → SAIDA.
  - Both edges in the same cycle → SAIDA.
- SENHA: ESTADO_FRASE = PARE; LED_AZUL toggles each tick, starting 0.
  - A BOTOES value with exactly one bit set shifts that digit in. Zero or multiple bits set are ignored.
  - After SENHA_DIGITOS digits, compare with SENHA in the next cycle:
    - Match → ENTRADA; tentativas cleared.
    - Mismatch → tentativas+1 → ERRO.
  - TIMEOUT_S → OCIOSO. The digit buffer is cleared on every entry.
- ERRO: ESTADO_FRASE = ERRO, LED_VERMELHO = 1. After ERRO_S → BLOQUEIO if tentativas == MAX_TENTATIVAS, else SENHA.
- BLOQUEIO: same outputs as ERRO; buttons ignored. After BLOQUEIO_S → OCIOSO with tentativas = 0.
- ENTRADA: CANCELA = 1, LED_VERDE = 1, ESTADO_FRASE = LIBERADO.
  - Internal sensor high → mark "passou".
  - "passou" and both sensors low → OCUPACAO+1 (saturating at CAPACIDADE) → OCIOSO.
  - TIMEOUT_S without "passou" → OCIOSO, no count.
- SAIDA: CANCELA = 1, ESTADO_FRASE = LIBERADO, LED_VERDE = 1.
  - External high → "passou".
  - "passou" and both low → OCUPACAO−1 (saturating at 0) → OCIOSO.
  - Timeout → OCIOSO, no count.
- tentativas persists across OCIOSO (it is not cleared by timeout); it is cleared only by a correct code, the end of a lockout, or RESET.

## Timing
- Reset: state OCIOSO, every output 0, OCUPACAO 0, tentativas 0, digit buffer cleared. Asynchronous assertion; all registers change on release only at a CLK_DA_PLACA edge.
- Sensor pin edge → state change: 3 cycles (2 sync + 1 register).
- Last digit pulse → ENTRADA/ERRO registered 2 cycles later (load, compare).
- Counts change in the same edge as the return to OCIOSO; CHEIO follows combinationally from OCUPACAO.
- Timeouts: exactly N*CLK_HZ cycles after state entry.
- Button pulses arriving in the compare cycle are dropped.
- RESET mid-passage: gate closes immediately and no count change occurs.

## Configuration
- BLOQUEIO_EN defined: lockout enabled as above.
- BLOQUEIO_EN not defined: BLOQUEIO state and tentativas counter are not synthesised. ERRO always returns to SENHA after ERRO_S, and MAX_TENTATIVAS/BLOQUEIO_S are ignored.

## Test plan
Use CLK_HZ=10, CAPACIDADE=2, SENHA_DIGITOS=2, SENHA=4'b01_11, TIMEOUT_S=3, ERRO_S=1, MAX_TENTATIVAS=2, BLOQUEIO_S=2.
- Entry: external up; BOTOES 0010, 1000; internal up, then both down → CANCELA 1 from 2 cycles after last pulse, closes on both-low; OCUPACAO=1.
- Full: two entries, then external up → ESTADO_FRASE=0001, state stays OCIOSO, CANCELA 0. Then exit (internal up, external up, both down) → OCUPACAO=1, CHEIO=0.
- Wrong code twice (BOTOES 0001,0001): ERRO for 10 cycles, SENHA, ERRO again, then BLOQUEIO for 20 cycles. Buttons ignored during BLOQUEIO; back to OCIOSO. With BLOQUEIO_EN undefined: returns to SENHA instead.
- SENHA with no buttons → OCIOSO exactly 30 cycles after entry. LED_AZUL toggles at cycles 10 and 20.
- Simultaneous BOTOES=0011 → ignored, digit count unchanged. Exit at OCUPACAO=0 → stays 0.
- RESET pulse during ENTRADA → all outputs 0 asynchronously, OCUPACAO=0.

Source files
------------

// File: rtl/controle_acesso_parametrizado_if.sv
// Signal bundle between the parking-gate controller and its surroundings.
// Macro: none.
// Modports:
//   master - drives raw sensors and debounced button pulses, observes gate/LED/display outputs
//   slave  - the controller: consumes sensors/buttons, drives gate, LEDs, phrase select, occupancy
interface controle_acesso_parametrizado_if #(
  parameter int unsigned CAPACIDADE = 16
);
  localparam int unsigned OcupW = $clog2(CAPACIDADE + 1);

  logic             SENSOR_EXTERNO;
  logic             SENSOR_INTERNO;
  logic [3:0]       BOTOES;
  logic             CANCELA_DO_ESTACIONAMENTO;
  logic             LED_VERDE;
  logic             LED_VERMELHO;
  logic             LED_AZUL;
  logic [3:0]       ESTADO_FRASE;
  logic [OcupW-1:0] OCUPACAO;
  logic             CHEIO;

  modport master (
    output SENSOR_EXTERNO, SENSOR_INTERNO, BOTOES,
    input  CANCELA_DO_ESTACIONAMENTO, LED_VERDE, LED_VERMELHO, LED_AZUL,
    input  ESTADO_FRASE, OCUPACAO, CHEIO
  );

  modport slave (
    input  SENSOR_EXTERNO, SENSOR_INTERNO, BOTOES,
    output CANCELA_DO_ESTACIONAMENTO, LED_VERDE, LED_VERMELHO, LED_AZUL,
    output ESTADO_FRASE, OCUPACAO, CHEIO
  );
endinterface

// File: rtl/controle_acesso_parametrizado.sv
// Parametrised parking-gate controller: password-protected entry, free exit, occupancy
// counter against a capacity, and optional keypad lockout after repeated wrong codes.
// Optional feature macro: BLOQUEIO_EN (lockout state + wrong-code counter).
// Ports:
//   CLK_DA_PLACA - board clock
//   RESET        - asynchronous active-high reset
//   bus (slave)  - sensors, buttons in; gate, LEDs, phrase select, occupancy, full flag out
module controle_acesso_parametrizado #(
  parameter int unsigned              CLK_HZ         = 50_000_000,
  parameter int unsigned              CAPACIDADE     = 16,
  parameter int unsigned              SENHA_DIGITOS  = 4,
  parameter logic [2*SENHA_DIGITOS-1:0] SENHA        = 8'b00_01_10_11,
  parameter int unsigned              TIMEOUT_S      = 20,
  parameter int unsigned              ERRO_S         = 2,
  parameter int unsigned              MAX_TENTATIVAS = 3,
  parameter int unsigned              BLOQUEIO_S     = 30
) (
  input logic                           CLK_DA_PLACA,
  input logic                           RESET,
  controle_acesso_parametrizado_if.slave bus
);
  localparam int unsigned OcupW  = $clog2(CAPACIDADE + 1);
  localparam int unsigned PrescW = $clog2(CLK_HZ + 1);
  localparam int unsigned SenhaW = 2 * SENHA_DIGITOS;
  localparam int unsigned CntW   = $clog2(SENHA_DIGITOS + 1);
  localparam int unsigned MaxS0  = (TIMEOUT_S > ERRO_S) ? TIMEOUT_S : ERRO_S;
  localparam int unsigned MaxS   = (MaxS0 > BLOQUEIO_S) ? MaxS0 : BLOQUEIO_S;
  localparam int unsigned SegW   = $clog2(MaxS + 1);

  if (CAPACIDADE < 1 || SENHA_DIGITOS < 1 || SENHA_DIGITOS > 8 || MAX_TENTATIVAS < 1 ||
      CLK_HZ < 1) begin : g_param_invalido
    $error("controle_acesso_parametrizado: invalid parameter set");
  end

  typedef enum logic [2:0] {
    StOcioso, StSenha, StErro, StEntrada, StSaida
`ifdef BLOQUEIO_EN
    , StBloqueio
`endif
  } estado_e;

  estado_e r_estado, w_estado_d;

  // Sensor synchronisers; the third flop only serves rising-edge detection.
  logic r_ext_s1, r_ext_s2, r_ext_s3, r_int_s1, r_int_s2, r_int_s3;
  logic w_ext_sobe, w_int_sobe;

  logic [PrescW-1:0] r_presc;
  logic [SegW-1:0]   r_seg;
  logic              r_azul;
  logic              w_tick, w_fim_timeout, w_fim_erro, w_mudou;

  logic [SenhaW-1:0] r_digitos;
  logic [CntW-1:0]   r_cnt;
  logic              w_botao_ok, w_completo;
  logic [1:0]        w_digito;

  logic             r_passou, w_passagem_ok;
  logic [OcupW-1:0] r_ocup;
  logic             w_cheio;

  logic       w_cancela, w_verde, w_vermelho, w_azul;
  logic [3:0] w_frase;

  assign w_ext_sobe = r_ext_s2 & ~r_ext_s3;
  assign w_int_sobe = r_int_s2 & ~r_int_s3;

  // Tick lands exactly CLK_HZ cycles after the last restart of the prescaler.
  assign w_tick        = (r_presc == PrescW'(CLK_HZ - 1));
  assign w_fim_timeout = w_tick && (r_seg == SegW'(TIMEOUT_S - 1));
  assign w_fim_erro    = w_tick && (r_seg == SegW'(ERRO_S - 1));
  assign w_mudou       = (w_estado_d != r_estado);

  assign w_botao_ok    = $onehot(bus.BOTOES);
  assign w_digito      = {bus.BOTOES[3] | bus.BOTOES[2], bus.BOTOES[3] | bus.BOTOES[1]};
  assign w_completo    = (r_cnt == CntW'(SENHA_DIGITOS));

  assign w_passagem_ok = r_passou & ~r_ext_s2 & ~r_int_s2;
  assign w_cheio       = (r_ocup == OcupW'(CAPACIDADE));

`ifdef BLOQUEIO_EN
  localparam int unsigned TentW = $clog2(MAX_TENTATIVAS + 1);
  logic [TentW-1:0] r_tent;
  logic             w_fim_bloq;
  assign w_fim_bloq = w_tick && (r_seg == SegW'(BLOQUEIO_S - 1));

  always_ff @(posedge CLK_DA_PLACA or posedge RESET) begin
    if (RESET) begin
      r_tent <= '0;
    end else if (r_estado == StSenha && w_estado_d == StErro) begin
      r_tent <= r_tent + 1'b1;
    end else if ((r_estado == StSenha && w_estado_d == StEntrada) ||
                 (r_estado == StBloqueio && w_estado_d == StOcioso)) begin
      r_tent <= '0;
    end
  end
`endif

  always_ff @(posedge CLK_DA_PLACA or posedge RESET) begin
    if (RESET) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
      r_ext_s3 <= 1'b0;
      r_int_s1 <= 1'b0;
      r_int_s2 <= 1'b0;
      r_int_s3 <= 1'b0;
    end else begin
      r_ext_s1 <= bus.SENSOR_EXTERNO;
      r_ext_s2 <= r_ext_s1;
      r_ext_s3 <= r_ext_s2;
      r_int_s1 <= bus.SENSOR_INTERNO;
      r_int_s2 <= r_int_s1;
      r_int_s3 <= r_int_s2;
    end
  end

  // Timer, blink, digit buffer and passage flag all restart with each state change.
  always_ff @(posedge CLK_DA_PLACA or posedge RESET) begin
    if (RESET) begin
      r_estado  <= StOcioso;
      r_presc   <= '0;
      r_seg     <= '0;
      r_azul    <= 1'b0;
      r_digitos <= '0;
      r_cnt     <= '0;
      r_passou  <= 1'b0;
    end else begin
      r_estado <= w_estado_d;
      if (w_mudou) begin
        r_presc <= '0;
        r_seg   <= '0;
        r_azul  <= 1'b0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_seg   <= r_seg + 1'b1;
        r_azul  <= ~r_azul;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (w_mudou || r_estado != StSenha) begin
        r_digitos <= '0;
        r_cnt     <= '0;
      end else if (w_botao_ok && !w_completo) begin
        r_digitos <= (r_digitos << 2) | SenhaW'(w_digito);
        r_cnt     <= r_cnt + 1'b1;
      end

      if (w_mudou) begin
        r_passou <= 1'b0;
      end else if ((r_estado == StEntrada && r_int_s2) || (r_estado == StSaida && r_ext_s2)) begin
        r_passou <= 1'b1;
      end
    end
  end

  // Occupancy moves on the same edge that returns the FSM to idle after a passage.
  always_ff @(posedge CLK_DA_PLACA or posedge RESET) begin
    if (RESET) begin
      r_ocup <= '0;
    end else if (r_estado == StEntrada && w_passagem_ok && !w_cheio) begin
      r_ocup <= r_ocup + 1'b1;
    end else if (r_estado == StSaida && w_passagem_ok && r_ocup != '0) begin
      r_ocup <= r_ocup - 1'b1;
    end
  end

  always_comb begin
    w_estado_d = r_estado;
    w_cancela  = 1'b0;
    w_verde    = 1'b0;
    w_vermelho = 1'b0;
    w_azul     = 1'b0;
    w_frase    = 4'b0000;
    unique case (r_estado)
      StOcioso: begin
        w_frase = {3'b000, w_cheio & r_ext_s2};
        if (w_int_sobe) w_estado_d = StSaida;
        else if (w_ext_sobe && !w_cheio) w_estado_d = StSenha;
      end
      StSenha: begin
        w_frase = 4'b0010;
        w_azul  = r_azul;
        if (w_completo) w_estado_d = (r_digitos == SENHA) ? StEntrada : StErro;
        else if (w_fim_timeout) w_estado_d = StOcioso;
      end
      StErro: begin
        w_frase    = 4'b1000;
        w_vermelho = 1'b1;
`ifdef BLOQUEIO_EN
        if (w_fim_erro)
          w_estado_d = (r_tent == TentW'(MAX_TENTATIVAS)) ? StBloqueio : StSenha;
`else
        if (w_fim_erro) w_estado_d = StSenha;
`endif
      end
`ifdef BLOQUEIO_EN
      StBloqueio: begin
        w_frase    = 4'b1000;
        w_vermelho = 1'b1;
        if (w_fim_bloq) w_estado_d = StOcioso;
      end
`endif
      StEntrada, StSaida: begin
        w_cancela = 1'b1;
        w_verde   = 1'b1;
        w_frase   = 4'b0100;
        if (w_passagem_ok || (w_fim_timeout && !r_passou)) w_estado_d = StOcioso;
      end
      default: w_estado_d = StOcioso;
    endcase
  end

  assign bus.CANCELA_DO_ESTACIONAMENTO = w_cancela;
  assign bus.LED_VERDE                 = w_verde;
  assign bus.LED_VERMELHO              = w_vermelho;
  assign bus.LED_AZUL                  = w_azul;
  assign bus.ESTADO_FRASE              = w_frase;
  assign bus.OCUPACAO                  = r_ocup;
  assign bus.CHEIO                     = w_cheio;
endmodule

// File: tb/tb_controle_acesso_parametrizado.sv
// Self-checking bench for controle_acesso_parametrizado: directed scenarios followed by
// randomized entry/exit sessions checked against a behavioural model (occupancy, attempts).
// Honours BLOQUEIO_EN the same way as the design.
module tb_controle_acesso_parametrizado;
  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned CAP    = 2;
  localparam int unsigned NDIG   = 2;
  localparam int unsigned TO_S   = 3;
  localparam int unsigned ERRO_S = 1;
  localparam int unsigned MAX_T  = 2;
  localparam int unsigned BLOQ_S = 2;
  localparam logic [3:0]  SENHA  = 4'b01_11;
  localparam int unsigned OW     = $clog2(CAP + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ocup  = 0;
  int   m_tent  = 0;
  logic [3:0] inval [5] = '{4'b0011, 4'b0101, 4'b1100, 4'b1111, 4'b0000};

  controle_acesso_parametrizado_if #(.CAPACIDADE(CAP)) u_if ();

  controle_acesso_parametrizado #(
    .CLK_HZ(CLK_HZ), .CAPACIDADE(CAP), .SENHA_DIGITOS(NDIG), .SENHA(SENHA),
    .TIMEOUT_S(TO_S), .ERRO_S(ERRO_S), .MAX_TENTATIVAS(MAX_T), .BLOQUEIO_S(BLOQ_S)
  ) u_dut (
    .CLK_DA_PLACA(clk),
    .RESET(rst),
    .bus(u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] b);
    u_if.BOTOES = b;
    step(1);
    u_if.BOTOES = 4'b0000;
  endtask

  task automatic seq_entrada();
    u_if.SENSOR_EXTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b0;
    press(4'b0010);
    press(4'b1000);
    step(1);
    u_if.SENSOR_INTERNO = 1'b1;
    step(3);
    u_if.SENSOR_INTERNO = 1'b0;
    step(3);
    m_ocup = (m_ocup < CAP) ? m_ocup + 1 : m_ocup;
    m_tent = 0;
  endtask

  task automatic seq_saida();
    u_if.SENSOR_INTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b0;
    u_if.SENSOR_INTERNO = 1'b0;
    step(3);
    m_ocup = (m_ocup > 0) ? m_ocup - 1 : 0;
  endtask

  task automatic test_reset();
    u_if.SENSOR_EXTERNO = 1'b0;
    u_if.SENSOR_INTERNO = 1'b0;
    u_if.BOTOES = 4'b0000;
    step(3);
    n_tests++;
    if ({u_if.CANCELA_DO_ESTACIONAMENTO, u_if.LED_VERDE, u_if.LED_VERMELHO, u_if.LED_AZUL,
         u_if.ESTADO_FRASE, u_if.CHEIO} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got gate=%b frase=%b want all 0",
               u_if.CANCELA_DO_ESTACIONAMENTO, u_if.ESTADO_FRASE);
    end
    n_tests++;
    if (u_if.OCUPACAO !== OW'(0)) begin
      n_fail++;
      $display("FAIL reset_ocupacao got %0d want 0", u_if.OCUPACAO);
    end
    rst = 1'b0;
    step(3);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0000 || u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got frase=%b want 0000", u_if.ESTADO_FRASE);
    end
  endtask

  task automatic test_entry();
    u_if.SENSOR_EXTERNO = 1'b1;
    step(2);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0000) begin
      n_fail++;
      $display("FAIL entry_sync_latency got frase=%b want 0000", u_if.ESTADO_FRASE);
    end
    step(1);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0010 || u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0) begin
      n_fail++;
      $display("FAIL entry_senha got frase=%b want 0010", u_if.ESTADO_FRASE);
    end
    press(4'b0010);
    press(4'b1000);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0010 || u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0) begin
      n_fail++;
      $display("FAIL entry_compare_cycle got frase=%b want 0010", u_if.ESTADO_FRASE);
    end
    step(1);
    n_tests++;
    if (u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b1 || u_if.LED_VERDE !== 1'b1 ||
        u_if.ESTADO_FRASE !== 4'b0100) begin
      n_fail++;
      $display("FAIL entry_open got gate=%b verde=%b frase=%b want 1 1 0100",
               u_if.CANCELA_DO_ESTACIONAMENTO, u_if.LED_VERDE, u_if.ESTADO_FRASE);
    end
    u_if.SENSOR_INTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b0;
    u_if.SENSOR_INTERNO = 1'b0;
    step(2);
    n_tests++;
    if (u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b1) begin
      n_fail++;
      $display("FAIL entry_still_open got %b want 1", u_if.CANCELA_DO_ESTACIONAMENTO);
    end
    step(1);
    m_ocup = 1;
    n_tests++;
    if (u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0 || u_if.OCUPACAO !== OW'(m_ocup)) begin
      n_fail++;
      $display("FAIL entry_closed got gate=%b ocup=%0d want 0 %0d",
               u_if.CANCELA_DO_ESTACIONAMENTO, u_if.OCUPACAO, m_ocup);
    end
  endtask

  task automatic test_full();
    seq_entrada();
    n_tests++;
    if (u_if.OCUPACAO !== OW'(m_ocup) || u_if.CHEIO !== 1'b1) begin
      n_fail++;
      $display("FAIL full_count got ocup=%0d cheio=%b want %0d 1", u_if.OCUPACAO, u_if.CHEIO,
               m_ocup);
    end
    u_if.SENSOR_EXTERNO = 1'b1;
    step(3);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0001 || u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0) begin
      n_fail++;
      $display("FAIL full_phrase got frase=%b want 0001", u_if.ESTADO_FRASE);
    end
    step(5);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0001) begin
      n_fail++;
      $display("FAIL full_stays_idle got frase=%b want 0001", u_if.ESTADO_FRASE);
    end
    u_if.SENSOR_EXTERNO = 1'b0;
    step(3);
    u_if.SENSOR_INTERNO = 1'b1;
    step(3);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0100 || u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_open got frase=%b want 0100", u_if.ESTADO_FRASE);
    end
    u_if.SENSOR_EXTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b0;
    u_if.SENSOR_INTERNO = 1'b0;
    step(3);
    m_ocup = m_ocup - 1;
    n_tests++;
    if (u_if.OCUPACAO !== OW'(m_ocup) || u_if.CHEIO !== 1'b0 ||
        u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_count got ocup=%0d cheio=%b want %0d 0", u_if.OCUPACAO, u_if.CHEIO,
               m_ocup);
    end
  endtask

  task automatic test_wrong_code();
    u_if.SENSOR_EXTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b0;
    press(4'b0001);
    press(4'b0001);
    step(1);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b1000 || u_if.LED_VERMELHO !== 1'b1) begin
      n_fail++;
      $display("FAIL wrong1_erro got frase=%b red=%b want 1000 1", u_if.ESTADO_FRASE,
               u_if.LED_VERMELHO);
    end
    step(9);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrong1_erro_hold got frase=%b want 1000", u_if.ESTADO_FRASE);
    end
    step(1);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0010 || u_if.LED_VERMELHO !== 1'b0) begin
      n_fail++;
      $display("FAIL wrong1_back_senha got frase=%b want 0010", u_if.ESTADO_FRASE);
    end
    press(4'b0001);
    press(4'b0001);
    step(1);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrong2_erro got frase=%b want 1000", u_if.ESTADO_FRASE);
    end
    step(10);
`ifdef BLOQUEIO_EN
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b1000 || u_if.LED_VERMELHO !== 1'b1) begin
      n_fail++;
      $display("FAIL lockout_entered got frase=%b want 1000", u_if.ESTADO_FRASE);
    end
    press(4'b0010);
    press(4'b1000);
    step(17);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b1000 || u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0) begin
      n_fail++;
      $display("FAIL lockout_ignores_buttons got frase=%b want 1000", u_if.ESTADO_FRASE);
    end
    step(1);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0000 || u_if.LED_VERMELHO !== 1'b0) begin
      n_fail++;
      $display("FAIL lockout_end got frase=%b want 0000", u_if.ESTADO_FRASE);
    end
    m_tent = 0;
`else
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0010) begin
      n_fail++;
      $display("FAIL no_lockout_senha got frase=%b want 0010", u_if.ESTADO_FRASE);
    end
    step(30);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0000) begin
      n_fail++;
      $display("FAIL no_lockout_timeout got frase=%b want 0000", u_if.ESTADO_FRASE);
    end
`endif
  endtask

  task automatic test_timeout();
    u_if.SENSOR_EXTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b0;
    step(9);
    n_tests++;
    if (u_if.LED_AZUL !== 1'b0) begin
      n_fail++;
      $display("FAIL azul_before_tick got %b want 0", u_if.LED_AZUL);
    end
    step(1);
    n_tests++;
    if (u_if.LED_AZUL !== 1'b1) begin
      n_fail++;
      $display("FAIL azul_tick1 got %b want 1", u_if.LED_AZUL);
    end
    step(10);
    n_tests++;
    if (u_if.LED_AZUL !== 1'b0) begin
      n_fail++;
      $display("FAIL azul_tick2 got %b want 0", u_if.LED_AZUL);
    end
    step(9);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0010) begin
      n_fail++;
      $display("FAIL timeout_early got frase=%b want 0010", u_if.ESTADO_FRASE);
    end
    step(1);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_exact got frase=%b want 0000", u_if.ESTADO_FRASE);
    end
  endtask

  task automatic test_invalid_buttons_and_empty_exit();
    u_if.SENSOR_EXTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b0;
    press(4'b0011);
    press(4'b0010);
    step(1);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0010) begin
      n_fail++;
      $display("FAIL multi_bit_ignored got frase=%b want 0010", u_if.ESTADO_FRASE);
    end
    press(4'b1000);
    step(1);
    n_tests++;
    if (u_if.ESTADO_FRASE !== 4'b0100) begin
      n_fail++;
      $display("FAIL code_after_multi got frase=%b want 0100", u_if.ESTADO_FRASE);
    end
    u_if.SENSOR_INTERNO = 1'b1;
    step(3);
    u_if.SENSOR_INTERNO = 1'b0;
    step(3);
    m_ocup = (m_ocup < CAP) ? m_ocup + 1 : m_ocup;
    for (int i = 0; i < 3; i++) begin
      seq_saida();
      n_tests++;
      if (u_if.OCUPACAO !== OW'(m_ocup)) begin
        n_fail++;
        $display("FAIL exit_saturate[%0d] got %0d want %0d", i, u_if.OCUPACAO, m_ocup);
      end
    end
  endtask

  task automatic test_reset_mid_passage();
    seq_entrada();
    u_if.SENSOR_EXTERNO = 1'b1;
    step(3);
    u_if.SENSOR_EXTERNO = 1'b0;
    press(4'b0010);
    press(4'b1000);
    step(1);
    u_if.SENSOR_INTERNO = 1'b1;
    step(3);
    n_tests++;
    if (u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b1 || u_if.OCUPACAO !== OW'(m_ocup)) begin
      n_fail++;
      $display("FAIL pre_reset_open got gate=%b ocup=%0d want 1 %0d",
               u_if.CANCELA_DO_ESTACIONAMENTO, u_if.OCUPACAO, m_ocup);
    end
    u_if.SENSOR_INTERNO = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_ocup = 0;
    m_tent = 0;
    n_tests++;
    if (u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0 || u_if.LED_VERDE !== 1'b0 ||
        u_if.ESTADO_FRASE !== 4'b0000 || u_if.OCUPACAO !== OW'(0)) begin
      n_fail++;
      $display("FAIL async_reset got gate=%b frase=%b ocup=%0d want 0 0000 0",
               u_if.CANCELA_DO_ESTACIONAMENTO, u_if.ESTADO_FRASE, u_if.OCUPACAO);
    end
    step(2);
    rst = 1'b0;
    step(3);
    n_tests++;
    if (u_if.OCUPACAO !== OW'(0) || u_if.ESTADO_FRASE !== 4'b0000) begin
      n_fail++;
      $display("FAIL after_reset_release got ocup=%0d frase=%b want 0 0000", u_if.OCUPACAO,
               u_if.ESTADO_FRASE);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        u_if.SENSOR_EXTERNO = 1'b1;
        step(3);
        if (m_ocup == CAP) begin
          n_tests++;
          if (u_if.ESTADO_FRASE !== 4'b0001) begin
            n_fail++;
            $display("FAIL rnd[%0d]_full got frase=%b want 0001", it, u_if.ESTADO_FRASE);
          end
          u_if.SENSOR_EXTERNO = 1'b0;
          step(3);
        end else begin
          logic [3:0] code;
          n_tests++;
          if (u_if.ESTADO_FRASE !== 4'b0010) begin
            n_fail++;
            $display("FAIL rnd[%0d]_senha got frase=%b want 0010", it, u_if.ESTADO_FRASE);
          end
          u_if.SENSOR_EXTERNO = 1'b0;
          code = ($urandom_range(0, 1) != 0) ? SENHA : 4'($urandom);
          for (int d = 0; d < NDIG; d++) begin
            logic [1:0] dig;
            step($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) press(inval[$urandom_range(0, 4)]);
            dig = code[2 * (NDIG - 1 - d) +: 2];
            press(4'b0001 << dig);
          end
          step(1);
          if (code == SENHA) begin
            n_tests++;
            if (u_if.ESTADO_FRASE !== 4'b0100 || u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b1) begin
              n_fail++;
              $display("FAIL rnd[%0d]_granted code=%b got frase=%b want 0100", it, code,
                       u_if.ESTADO_FRASE);
            end
            u_if.SENSOR_INTERNO = 1'b1;
            step($urandom_range(3, 6));
            u_if.SENSOR_INTERNO = 1'b0;
            step(3);
            m_ocup = (m_ocup < CAP) ? m_ocup + 1 : m_ocup;
            m_tent = 0;
          end else begin
            m_tent++;
            n_tests++;
            if (u_if.ESTADO_FRASE !== 4'b1000) begin
              n_fail++;
              $display("FAIL rnd[%0d]_denied code=%b got frase=%b want 1000", it, code,
                       u_if.ESTADO_FRASE);
            end
            step(10);
`ifdef BLOQUEIO_EN
            if (m_tent == MAX_T) begin
              n_tests++;
              if (u_if.ESTADO_FRASE !== 4'b1000) begin
                n_fail++;
                $display("FAIL rnd[%0d]_lockout got frase=%b want 1000", it, u_if.ESTADO_FRASE);
              end
              step(20);
              m_tent = 0;
            end else
`endif
            begin
              n_tests++;
              if (u_if.ESTADO_FRASE !== 4'b0010) begin
                n_fail++;
                $display("FAIL rnd[%0d]_retry got frase=%b want 0010", it, u_if.ESTADO_FRASE);
              end
              step(30);
            end
          end
          n_tests++;
          if (u_if.ESTADO_FRASE !== 4'b0000 || u_if.CANCELA_DO_ESTACIONAMENTO !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd[%0d]_idle got frase=%b want 0000", it, u_if.ESTADO_FRASE);
          end
        end
      end else begin
        seq_saida();
      end
      n_tests++;
      if (u_if.OCUPACAO !== OW'(m_ocup) || u_if.CHEIO !== (m_ocup == CAP)) begin
        n_fail++;
        $display("FAIL rnd[%0d]_ocupacao got %0d cheio=%b want %0d", it, u_if.OCUPACAO,
                 u_if.CHEIO, m_ocup);
      end
    end
  endtask

  initial begin
    u_if.SENSOR_EXTERNO = 1'b0;
    u_if.SENSOR_INTERNO = 1'b0;
    u_if.BOTOES = 4'b0000;
    test_reset();
    test_entry();
    test_full();
    test_wrong_code();
    test_timeout();
    test_invalid_buttons_and_empty_exit();
    test_reset_mid_passage();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
